// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate test sequencer: FSM state encoding,
// common two-input truth tables and the vector-space helper.
package gate_seq_pkg;

    // FSM state set, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } gate_seq_state_e;

    // Same encoding as plain constants for logic-typed state registers
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Truth tables: bit i is the expected output for input vector i
    localparam logic [3:0] TRUTH_AND2  = 4'b1000;
    localparam logic [3:0] TRUTH_OR2   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR2  = 4'b0110;
    localparam logic [3:0] TRUTH_NAND2 = 4'b0111;

    // Number of distinct input vectors for an n-input gate
    function automatic int num_vectors(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/gate_seq_hold_timer.sv
// Loadable down-counter that times how long each vector is held.
// load reloads HOLD_CYCLES-1; en decrements until zero; zero flags the
// final cycle of the hold window.
module gate_seq_hold_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = $clog2(HOLD_CYCLES + 1);
    localparam logic [W-1:0] RELOAD = W'(HOLD_CYCLES - 1);

    logic [W-1:0] count;

    // Reload takes priority; otherwise count down and stick at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive self-checking sequencer for a small combinational gate.
// On start it walks every input vector, holds each for HOLD_CYCLES cycles,
// samples gate_out in the last cycle of each hold window and compares it
// against TRUTH. Results (pass, err_count, first failing vector) are held
// until the next start.
//
// Optional build macro GATE_SEQ_STOP_ON_FAIL_EN: when defined, the first
// mismatch ends the run immediately instead of walking the remaining vectors.
//
// Handshake: start is a level sampled only while the FSM is idle; a high
// start in any other state is dropped, never queued. done is a one-cycle
// pulse; pass/err_count/fail_vec are stable from the done cycle onward.
module gate_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int                    N_IN        = 2,
    parameter int                    HOLD_CYCLES = 5,
    parameter logic [2**N_IN-1:0]    TRUTH       = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic [1:0]      fsm_state
);

    localparam int              NUM_VEC  = num_vectors(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NUM_VEC - 1);
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic [1:0]      state;
    logic [N_IN-1:0] vec;
    logic            hold_zero;
    logic            hold_load;
    logic            hold_en;
    logic            sample;
    logic            mismatch;
    logic            last;
    logic [N_IN:0]   err_next;

    // Sample point is the final cycle of each hold window
    assign sample   = (state == ST_APPLY) && hold_zero;
    // 4-state compare so an undriven or unknown gate output counts as a miss
    assign mismatch = sample && (gate_out !== TRUTH[vec]);
    // Run ends after the last vector, or at the first miss in stop-on-fail builds
    assign last     = (vec == LAST_VEC) || (STOP_ON_FAIL && mismatch);
    assign err_next = err_count + (N_IN+1)'(mismatch);

    // Timer reloads on run start and on every step to the next vector
    assign hold_load = ((state == ST_IDLE) && start) || (sample && !last);
    assign hold_en   = (state == ST_APPLY) && !hold_zero;

    gate_seq_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hold_load),
        .en    (hold_en),
        .zero  (hold_zero)
    );

    // Run FSM, vector counter and result scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= '0;
            gate_in   <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_APPLY;
                        vec       <= '0;
                        gate_in   <= '0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                ST_APPLY: begin
                    if (sample) begin
                        if (mismatch) begin
                            err_count <= err_next;
                            if (err_count == '0) begin
                                fail_vec <= vec;
                            end
                        end
                        if (last) begin
                            state   <= ST_DONE;
                            pass    <= (err_next == '0);
                            vec     <= '0;
                            gate_in <= '0;
                        end else begin
                            vec     <= vec + VEC_ONE;
                            gate_in <= vec + VEC_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == ST_APPLY);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: two instances (default AND/hold 5, and
// XOR/hold 1), a behavioural run model computed from vector arithmetic,
// a per-cycle compare process, directed scenarios and a randomized phase.
module tb_gate_test_sequencer;
    import gate_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] start_s;

    wire  [1:0] gi      [2];
    wire  [1:0] gout;
    wire  [1:0] busy_s;
    wire  [1:0] done_s;
    wire  [1:0] pass_s;
    wire  [2:0] err_s   [2];
    wire  [1:0] fail_s  [2];
    wire  [1:0] st_s    [2];

    // gate modes: 0 AND, 1 stuck-at-0, 2 stuck-at-1, 3 XOR, 4 random table
    int         mode [2];
    logic [3:0] rtab [2];
    logic [3:0] truth_c [2] = '{TRUTH_AND2, TRUTH_XOR2};
    int         hold_c  [2] = '{5, 1};

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic gate_fn(input int m, input logic [3:0] tab, input logic [1:0] v);
        case (m)
            0:       return v[0] & v[1];
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return v[0] ^ v[1];
            default: return tab[v];
        endcase
    endfunction

    assign gout[0] = gate_fn(mode[0], rtab[0], gi[0]);
    assign gout[1] = gate_fn(mode[1], rtab[1], gi[1]);

    gate_test_sequencer dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[0]),
        .gate_in   (gi[0]),
        .gate_out  (gout[0]),
        .busy      (busy_s[0]),
        .done      (done_s[0]),
        .pass      (pass_s[0]),
        .err_count (err_s[0]),
        .fail_vec  (fail_s[0]),
        .fsm_state (st_s[0])
    );

    gate_test_sequencer #(
        .N_IN        (2),
        .HOLD_CYCLES (1),
        .TRUTH       (TRUTH_XOR2)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[1]),
        .gate_in   (gi[1]),
        .gate_out  (gout[1]),
        .busy      (busy_s[1]),
        .done      (done_s[1]),
        .pass      (pass_s[1]),
        .err_count (err_s[1]),
        .fail_vec  (fail_s[1]),
        .fsm_state (st_s[1])
    );

    // ---------------- checker ----------------
    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is described by its length in cycles, the per-vector miss list,
    // and the time index since the start edge.
    bit         m_act   [2];
    int         m_t     [2];
    int         m_len   [2];
    int         m_napp  [2];
    int         m_first [2];
    bit         m_mis   [2][4];
    int         f_err   [2];
    int         h_err   [2];
    int         h_fail  [2];
    int         h_pass  [2];

    task automatic plan_run(input int d);
        int first;
        int napp;
        int cnt;
        first = -1;
        for (int v = 0; v < 4; v++) begin
            m_mis[d][v] = (gate_fn(mode[d], rtab[d], 2'(v)) !== truth_c[d][v]);
            if (m_mis[d][v] && first < 0) first = v;
        end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        napp = (first >= 0) ? first + 1 : 4;
`else
        napp = 4;
`endif
        cnt = 0;
        for (int v = 0; v < napp; v++) if (m_mis[d][v]) cnt++;
        m_first[d] = first;
        m_napp[d]  = napp;
        m_len[d]   = napp * hold_c[d];
        f_err[d]   = cnt;
    endtask

    function automatic int err_at(input int d, input int t);
        int c = 0;
        for (int v = 0; v < m_napp[d]; v++)
            if (m_mis[d][v] && ((v + 1) * hold_c[d] <= t)) c++;
        return c;
    endfunction

    // Model advances on each clock edge and clears on asynchronous reset
    initial begin : model_proc
        bit was_idle;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    m_act[d]  = 1'b0;
                    m_t[d]    = 0;
                    h_err[d]  = 0;
                    h_fail[d] = 0;
                    h_pass[d] = 0;
                end else begin
                    was_idle = !m_act[d];
                    if (m_act[d]) begin
                        m_t[d]++;
                        if (m_t[d] == m_len[d]) begin
                            h_err[d]  = f_err[d];
                            h_fail[d] = (m_first[d] >= 0) ? m_first[d] : 0;
                            h_pass[d] = (f_err[d] == 0) ? 1 : 0;
                        end else if (m_t[d] > m_len[d]) begin
                            m_act[d] = 1'b0;
                        end
                    end
                    if (was_idle && start_s[d]) begin
                        plan_run(d);
                        m_act[d]  = 1'b1;
                        m_t[d]    = 0;
                        h_err[d]  = 0;
                        h_fail[d] = 0;
                        h_pass[d] = 0;
                    end
                end
            end
        end
    end

    // Compare every output of both instances on each falling edge
    initial begin : compare_proc
        int e_busy, e_done, e_gi, e_err, e_fail, e_pass, e_st;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (m_act[d] && m_t[d] < m_len[d]) begin
                    e_busy = 1; e_done = 0; e_st = 1;
                    e_gi   = m_t[d] / hold_c[d];
                    e_err  = err_at(d, m_t[d]);
                    e_fail = (e_err > 0) ? m_first[d] : 0;
                    e_pass = 0;
                end else begin
                    e_busy = 0; e_gi = 0;
                    e_done = (m_act[d] && m_t[d] == m_len[d]) ? 1 : 0;
                    e_st   = e_done ? 2 : 0;
                    e_err  = h_err[d];
                    e_fail = h_fail[d];
                    e_pass = h_pass[d];
                end
                chk("busy",      d, 32'(busy_s[d]), e_busy);
                chk("done",      d, 32'(done_s[d]), e_done);
                chk("gate_in",   d, 32'(gi[d]),     e_gi);
                chk("err_count", d, 32'(err_s[d]),  e_err);
                chk("fail_vec",  d, 32'(fail_s[d]), e_fail);
                chk("pass",      d, 32'(pass_s[d]), e_pass);
                chk("state",     d, 32'(st_s[d]),   e_st);
            end
        end
    end

    // ---------------- driver ----------------
    // opt: 0 plain, 1 re-pulse start at busy cycles 3 and 12,
    //      2 async reset at busy cycle 8, 3 start held during done
    task automatic run(input int d, input int opt, output int bcnt);
        bit got_done;
        bit did_reset;
        got_done  = 1'b0;
        did_reset = 1'b0;
        bcnt      = 0;
        @(posedge clk); #1 start_s[d] = 1'b1;
        @(posedge clk); #1 start_s[d] = 1'b0;
        for (int i = 0; i < 100 && !got_done && !did_reset; i++) begin
            @(negedge clk);
            if (busy_s[d]) bcnt++;
            if (done_s[d]) begin
                got_done = 1'b1;
            end else if (opt == 1 && (bcnt == 3 || bcnt == 12)) begin
                start_s[d] = 1'b1;
                @(posedge clk); #1 start_s[d] = 1'b0;
            end else if (opt == 2 && bcnt == 8) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy",  d, 32'(busy_s[d]), 0);
                chk("rst_done",  d, 32'(done_s[d]), 0);
                chk("rst_gi",    d, 32'(gi[d]),     0);
                chk("rst_err",   d, 32'(err_s[d]),  0);
                chk("rst_fail",  d, 32'(fail_s[d]), 0);
                chk("rst_pass",  d, 32'(pass_s[d]), 0);
                chk("rst_state", d, 32'(st_s[d]),   0);
                @(posedge clk);
                @(posedge clk); #1 rst_n = 1'b1;
                did_reset = 1'b1;
            end
        end
        if (!did_reset) chk("run_done", d, 32'(got_done), 1);
        if (got_done && opt == 3) begin
            start_s[d] = 1'b1;
            @(posedge clk); #1 start_s[d] = 1'b0;
            @(negedge clk); chk("no_start_in_done", d, 32'(busy_s[d]), 0);
            @(negedge clk); chk("no_start_in_done", d, 32'(busy_s[d]), 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main_proc
        int bc;
        rst_n   = 1'b0;
        start_s = '0;
        mode[0] = 0; mode[1] = 3;
        rtab[0] = 4'h0; rtab[1] = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_err",  d, 32'(err_s[d]),  0);
            chk("reset_pass", d, 32'(pass_s[d]), 0);
            chk("reset_busy", d, 32'(busy_s[d]), 0);
        end

        // correct AND gate: full pass
        mode[0] = 0;
        run(0, 0, bc);
        chk("t1_busy_len", 0, bc, 20);
        chk("t1_pass",     0, 32'(pass_s[0]), 1);
        chk("t1_err",      0, 32'(err_s[0]),  0);

        // stuck-at-0
        mode[0] = 1;
        run(0, 0, bc);
        chk("t2_err",  0, 32'(err_s[0]),  1);
        chk("t2_fail", 0, 32'(fail_s[0]), 3);
        chk("t2_pass", 0, 32'(pass_s[0]), 0);

        // stuck-at-1
        mode[0] = 2;
        run(0, 0, bc);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        chk("t3_err",      0, 32'(err_s[0]), 1);
        chk("t3_busy_len", 0, bc, 5);
`else
        chk("t3_err",      0, 32'(err_s[0]), 3);
        chk("t3_busy_len", 0, bc, 20);
`endif
        chk("t3_fail", 0, 32'(fail_s[0]), 0);
        chk("t3_pass", 0, 32'(pass_s[0]), 0);

        // start re-pulsed mid-run is ignored
        mode[0] = 0;
        run(0, 1, bc);
        chk("t4_busy_len", 0, bc, 20);
        chk("t4_pass",     0, 32'(pass_s[0]), 1);

        // start held through the done pulse is ignored
        run(0, 3, bc);
        chk("t4b_busy_len", 0, bc, 20);

        // asynchronous reset mid-run, then a fresh full run
        mode[0] = 2;
        run(0, 2, bc);
        mode[0] = 0;
        run(0, 0, bc);
        chk("t5_busy_len", 0, bc, 20);
        chk("t5_pass",     0, 32'(pass_s[0]), 1);

        // hold of one cycle, XOR expected
        mode[1] = 3;
        run(1, 0, bc);
        chk("t6_busy_len", 1, bc, 4);
        chk("t6_pass",     1, 32'(pass_s[1]), 1);
        mode[1] = 0;
        run(1, 0, bc);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        chk("t6b_err",      1, 32'(err_s[1]), 1);
        chk("t6b_busy_len", 1, bc, 2);
`else
        chk("t6b_err",      1, 32'(err_s[1]), 3);
        chk("t6b_busy_len", 1, bc, 4);
`endif
        chk("t6b_fail", 1, 32'(fail_s[1]), 1);
        chk("t6b_pass", 1, 32'(pass_s[1]), 0);

        // randomized gates, scenarios and idle gaps
        for (int k = 0; k < 30; k++) begin
            int d;
            d       = $urandom_range(0, 1);
            mode[d] = $urandom_range(0, 4);
            rtab[d] = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run(d, $urandom_range(0, 3), bc);
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute bound on simulation time
    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
